// File: rtl/microstep_position_if.sv
// Step/direction bus between an external controller and the microstep position front end.
// The controller side uses master; the position logic uses slave.
interface microstep_position_if #(
  parameter int unsigned CYCLE_W = 16
);
  logic               enable;
  logic               step;
  logic               dir;
  logic [5:0]         step_size;
  logic               clear;
  logic [7:0]         pos;
  logic               pos_valid;
  logic [CYCLE_W-1:0] cycle_count;
  logic               fault;

  modport master (
    output enable, step, dir, step_size, clear,
    input  pos, pos_valid, cycle_count, fault
  );

  modport slave (
    input  enable, step, dir, step_size, clear,
    output pos, pos_valid, cycle_count, fault
  );
endinterface

// File: rtl/microstep_position.sv
// Converts asynchronous STEP/DIR pulses into the 0..191 electrical position with a
// signed electrical-cycle count and a sticky illegal-step-size fault.
module microstep_position #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CYCLE_W     = 16
) (
  input logic                  clk,
  input logic                  resetn,
  microstep_position_if.slave  bus
);

  localparam logic [8:0]         POS_SPAN = 9'd192;
  localparam logic [CYCLE_W-1:0] CYC_ONE  = {{(CYCLE_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] step_sync;
  logic [SYNC_STAGES-1:0] dir_sync;
  logic                   step_d;
  logic                   rise;
  logic                   dir_s;

  logic [7:0]         pos_q,   pos_n;
  logic [CYCLE_W-1:0] cyc_q,   cyc_n;
  logic               fault_q, fault_n;
  logic               valid_q, valid_n;

  logic [8:0] size9;
  logic [8:0] fwd_sum;
  logic [8:0] fwd_wrap;
  logic [8:0] rev_wrap;
  logic [8:0] rev_diff;
  logic       size_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_sync <= '0;
      dir_sync  <= '0;
      step_d    <= 1'b0;
      pos_q     <= '0;
      cyc_q     <= '0;
      fault_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      step_sync <= {step_sync[SYNC_STAGES-2:0], bus.step};
      dir_sync  <= {dir_sync[SYNC_STAGES-2:0], bus.dir};
      step_d    <= step_sync[SYNC_STAGES-1];
      pos_q     <= pos_n;
      cyc_q     <= cyc_n;
      fault_q   <= fault_n;
      valid_q   <= valid_n;
    end
  end

  // dir is tapped at the same stage as step so a step always sees its own direction
  assign rise  = step_sync[SYNC_STAGES-1] & ~step_d;
  assign dir_s = dir_sync[SYNC_STAGES-1];

  assign size9    = {3'b000, bus.step_size};
  assign fwd_sum  = {1'b0, pos_q} + size9;
  assign fwd_wrap = fwd_sum - POS_SPAN;
  assign rev_wrap = {1'b0, pos_q} + POS_SPAN - size9;
  assign rev_diff = {1'b0, pos_q} - size9;
  assign size_ok  = (bus.step_size != 6'd0) && (bus.step_size <= 6'd48);

  always_comb begin
    pos_n   = pos_q;
    cyc_n   = cyc_q;
    fault_n = fault_q;
    valid_n = 1'b0;
    if (bus.clear) begin
      pos_n   = '0;
      cyc_n   = '0;
      fault_n = 1'b0;
    end else if (rise && bus.enable) begin
      if (!size_ok) begin
        fault_n = 1'b1;
      end else begin
        valid_n = 1'b1;
        if (dir_s) begin
          if (fwd_sum >= POS_SPAN) begin
            pos_n = fwd_wrap[7:0];
            cyc_n = cyc_q + CYC_ONE;
          end else begin
            pos_n = fwd_sum[7:0];
          end
        end else begin
          if ({1'b0, pos_q} < size9) begin
            pos_n = rev_wrap[7:0];
            cyc_n = cyc_q - CYC_ONE;
          end else begin
            pos_n = rev_diff[7:0];
          end
        end
      end
    end
  end

  assign bus.pos         = pos_q;
  assign bus.cycle_count = cyc_q;
  assign bus.fault       = fault_q;
  assign bus.pos_valid   = valid_q;

endmodule

// File: tb/tb_microstep_position.sv
// Bench for microstep_position: directed table, corner-case sequences and random steps
// checked against an integer model of position/cycle arithmetic.
module tb_microstep_position;

  logic clk;
  logic resetn;

  microstep_position_if #(.CYCLE_W(16)) bus ();

  microstep_position #(
    .SYNC_STAGES(2),
    .CYCLE_W(16)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // integer reference model
  int m_pos;
  int m_cyc;
  bit m_fault;
  bit m_valid;

  // outputs captured in the update cycle of the last step
  logic [31:0] a_pos, a_cyc, a_fault, a_valid;

  typedef struct {
    bit clr;
    bit d;
    int sz;
    bit en;
    int e_pos;
    int e_cyc;
    bit e_fault;
    bit e_valid;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_step(input bit d, input int sz, input bit en);
    m_valid = 1'b0;
    if (!en) return;
    if (sz == 0 || sz > 48) begin
      m_fault = 1'b1;
      return;
    end
    m_valid = 1'b1;
    if (d) m_pos = m_pos + sz;
    else   m_pos = m_pos - sz;
    if (m_pos >= 192) begin m_pos -= 192; m_cyc++; end
    if (m_pos < 0)    begin m_pos += 192; m_cyc--; end
  endtask

  task automatic model_zero();
    m_pos = 0; m_cyc = 0; m_fault = 1'b0; m_valid = 1'b0;
  endtask

  // Raises step one half-cycle before edge N; update lands on edge N+2.
  task automatic run_step(input bit d, input int sz, input bit en);
    bus.dir       = d;
    bus.step_size = 6'(sz);
    bus.enable    = en;
    repeat (2) @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    chk("valid_early_n", 32'(bus.pos_valid), 32'd0);
    @(negedge clk);
    chk("valid_early_n1", 32'(bus.pos_valid), 32'd0);
    @(negedge clk);
    a_pos   = 32'(bus.pos);
    a_cyc   = 32'(bus.cycle_count);
    a_fault = 32'(bus.fault);
    a_valid = 32'(bus.pos_valid);
    bus.step = 1'b0;
    @(negedge clk);
    chk("valid_pulse_end", 32'(bus.pos_valid), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("clear_pos", 32'(bus.pos), 32'd0);
    chk("clear_cyc", 32'(bus.cycle_count), 32'd0);
    chk("clear_fault", 32'(bus.fault), 32'd0);
    model_zero();
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_pos"},   a_pos,   32'(m_pos));
    chk({tag, "_cyc"},   a_cyc,   32'(m_cyc & 32'hFFFF));
    chk({tag, "_fault"}, a_fault, 32'(m_fault));
    chk({tag, "_valid"}, a_valid, 32'(m_valid));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_zero();
    resetn        = 1'b0;
    bus.enable    = 1'b1;
    bus.step      = 1'b0;
    bus.dir       = 1'b1;
    bus.step_size = 6'd1;
    bus.clear     = 1'b0;

    tbl = '{
      '{0, 1, 48, 1,  48, 0,       0, 1},
      '{0, 1, 48, 1,  96, 0,       0, 1},
      '{0, 1, 48, 1, 144, 0,       0, 1},
      '{0, 1, 48, 1,   0, 1,       0, 1},
      '{1, 0,  3, 1, 189, 'hFFFF,  0, 1},
      '{0, 1,  3, 1,   0, 0,       0, 1},
      '{0, 1,  0, 1,   0, 0,       1, 0},
      '{0, 1, 49, 1,   0, 0,       1, 0},
      '{1, 1, 16, 1,  16, 0,       0, 1},
      '{0, 1, 16, 0,  16, 0,       0, 0},
      '{0, 1, 48, 1,  64, 0,       0, 1},
      '{0, 1, 48, 1, 112, 0,       0, 1},
      '{0, 1, 48, 1, 160, 0,       0, 1},
      '{0, 1, 24, 1, 184, 0,       0, 1},
      '{0, 1, 16, 1,   8, 1,       0, 1},
      '{0, 0,  8, 1,   0, 1,       0, 1},
      '{0, 0, 48, 1, 144, 0,       0, 1}
    };

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_pos", 32'(bus.pos), 32'd0);
    chk("rst_cyc", 32'(bus.cycle_count), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_valid", 32'(bus.pos_valid), 32'd0);

    // directed table
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].clr) do_clear();
      run_step(tbl[i].d, tbl[i].sz, tbl[i].en);
      chk($sformatf("tbl%0d_pos", i),   a_pos,   32'(tbl[i].e_pos));
      chk($sformatf("tbl%0d_cyc", i),   a_cyc,   32'(tbl[i].e_cyc));
      chk($sformatf("tbl%0d_fault", i), a_fault, 32'(tbl[i].e_fault));
      chk($sformatf("tbl%0d_valid", i), a_valid, 32'(tbl[i].e_valid));
    end

    // steps while disabled, then enable raised while step is high
    do_clear();
    run_step(1, 10, 1); model_step(1, 10, 1); cmp_model("en_pre");
    for (int i = 0; i < 3; i++) begin
      run_step(1, 7, 0); model_step(1, 7, 0); cmp_model("en_off");
    end
    bus.enable = 1'b0;
    bus.dir    = 1'b1;
    repeat (2) @(negedge clk);
    bus.step = 1'b1;
    repeat (4) @(negedge clk);
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("en_high_valid", 32'(bus.pos_valid), 32'd0);
      chk("en_high_pos", 32'(bus.pos), 32'(m_pos));
    end
    bus.step = 1'b0;
    repeat (3) @(negedge clk);
    run_step(1, 7, 1); model_step(1, 7, 1); cmp_model("en_next");

    // clear coincident with rise
    bus.dir = 1'b1; bus.step_size = 6'd5; bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    bus.step = 1'b1;
    repeat (2) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    model_zero();
    chk("clr_rise_pos", 32'(bus.pos), 32'd0);
    chk("clr_rise_valid", 32'(bus.pos_valid), 32'd0);
    bus.step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clr_after_valid", 32'(bus.pos_valid), 32'd0);
      chk("clr_after_pos", 32'(bus.pos), 32'd0);
    end

    // reset pulse while an edge is in the synchronizer
    run_step(1, 20, 1); model_step(1, 20, 1); cmp_model("rst_pre");
    bus.dir = 1'b1; bus.step_size = 6'd9;
    repeat (2) @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    resetn   = 1'b0;
    bus.step = 1'b0;
    #1;
    chk("rst_mid_pos", 32'(bus.pos), 32'd0);
    chk("rst_mid_valid", 32'(bus.pos_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_zero();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_after_valid", 32'(bus.pos_valid), 32'd0);
      chk("rst_after_pos", 32'(bus.pos), 32'd0);
    end

    // randomized steps against the model
    for (int i = 0; i < 60; i++) begin
      bit d;
      bit en;
      int sz;
      if ($urandom_range(0, 19) == 0) do_clear();
      d  = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) sz = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(49, 63));
      else                           sz = int'($urandom_range(1, 48));
      run_step(d, sz, en);
      model_step(d, sz, en);
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/microstep_position.md
# microstep_position

Step/direction front end for the microstepper. It turns asynchronous external STEP/DIR pulses into the 8-bit electrical-angle position `pos` (0..191, four 48-count quadrants) that the microstep cosine-index/phase-select logic consumes. It also keeps a signed count of completed electrical cycles and flags invalid step-size configuration.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops on `step` and `dir` ahead of the edge detector; legal values 2..3.
- `CYCLE_W`, default 16: width of `cycle_count`.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  while high, synchronized step edges are applied; while low, they are discarded.
- `step`  in  1  asynchronous step request; the rising edge is the event.
- `dir`  in  1  direction: 1 = forward (pos increases), 0 = reverse.
- `step_size`  in  6  position counts added per step; legal range 1..48, sampled in the cycle the edge is applied.
- `clear`  in  1  synchronous clear of position, cycle count and fault.
- `pos`  out  8  electrical position, always 0..191.
- `pos_valid`  out  1  one-cycle pulse in the cycle a new `pos` value first appears.
- `cycle_count`  out  `CYCLE_W`  two's-complement count of electrical-cycle wraps.
- `fault`  out  1  sticky flag: a step was rejected because `step_size` was illegal.

## Operation
- `step` and `dir` each pass through `SYNC_STAGES` flops, then through one more flop on `step` for edge detection.
- `rise` = (synced step) AND NOT (delayed step). `dir` is taken from the same synchronizer stage as `step`, so the two stay aligned.
- Priority each cycle, highest first:
  - `clear`: `pos`=0, `cycle_count`=0, `fault`=0, `pos_valid`=0. Any coincident `rise` is discarded.
  - `rise` with `enable` low: no change.
  - `rise` with `enable` high and `step_size` equal to 0 or greater than 48: `pos` and `cycle_count` hold, `fault` is set, `pos_valid`=0.
  - `rise` with `enable` high and a legal `step_size`: update as below, `pos_valid`=1.
  - Otherwise: `pos_valid`=0 and all other state holds.
- Arithmetic is done at 9-bit width.
  - Forward: s = pos + step_size. If s ≥ 192, pos ← s − 192 and `cycle_count` +1. Otherwise pos ← s.
  - Reverse: if pos < step_size, pos ← pos + 192 − step_size and `cycle_count` −1. Otherwise pos ← pos − step_size.
- `cycle_count` wraps modulo 2^`CYCLE_W` with no saturation.
- `fault` clears only on `clear` or reset.
- `pos` never leaves 0..191, which holds by construction given step_size ≤ 48.

## Timing
- Reset values: `pos`=0, `cycle_count`=0, `fault`=0, `pos_valid`=0, and all synchronizer and edge flops at 0.
  - A `step` already high when reset is released therefore produces one `rise`, and it is counted.
- Latency with `SYNC_STAGES`=2: if `step` goes high with setup before clock edge N, the updated `pos` and `pos_valid` are visible after edge N+2. Generally, they are visible after edge N+`SYNC_STAGES`.
- Input requirements:
  - `step` must stay high for at least `SYNC_STAGES` cycles and low for at least `SYNC_STAGES` cycles. Shorter pulses may be lost, but never double-counted.
  - `dir` must be stable from `SYNC_STAGES` cycles before the `step` rise until 1 cycle after it.
  - `step_size` is sampled synchronously, unsynchronized, in the update cycle, and must be static around step events.
- Maximum step rate is one step per 2·`SYNC_STAGES` cycles.
- `enable` falling mid-synchronization: an edge whose `rise` cycle sees `enable`=0 is dropped. Re-raising `enable` while `step` is high creates no edge.
- Asserting `resetn` mid-operation clears everything immediately, including any in-flight synchronized edge.

## Test plan
- Reset, then 4 forward steps with step_size=48 → `pos` 48, 96, 144, 0. `cycle_count`=1 after the 4th step. Each `pos_valid` is a single pulse exactly 2 cycles after its `step` rise.
- From pos=0, one reverse step with step_size=3 → pos=189, `cycle_count`=−1 (0xFFFF). Then a forward step with step_size=3 → pos=0, `cycle_count`=0.
- step_size=0, then step_size=49, each with a step → `pos` unchanged, no `pos_valid`, `fault`=1 stays set. Then `clear` → `fault`=0, pos=0.
- `enable`=0 while 3 steps are issued → no change. Raise `enable` while `step` is high → no update until the next low→high transition.
- `clear` asserted in the same cycle as `rise` → pos=0, `pos_valid`=0, and that step is not applied afterwards.
- Forward step_size=16 from pos=184 → pos=8, `cycle_count` +1. Also assert `resetn` low for 1 cycle while an edge is in the synchronizer → all outputs 0 and no update follows.
